// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and an index-width helper.
package uart_tx_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side signals of the transmit arbiter.
// Handshake: a byte of source i moves when req_valid[i] && req_ready[i] at a rising clk edge;
// req_ready is combinational and only ever set for the granted source while tx_full is low.
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8,
  parameter int LEN_BITS  = 4
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*LEN_BITS-1:0]  req_len;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           gnt;
  logic                         busy;
  logic                         pkt_done;
  logic [DATA_BITS-1:0]         w_data;
  logic                         wr_uart;
  logic                         tx_full;

  modport master (
    output req, req_len, req_data, req_valid, tx_full,
    input  req_ready, gnt, busy, pkt_done, w_data, wr_uart
  );

  modport slave (
    input  req, req_len, req_data, req_valid, tx_full,
    output req_ready, gnt, busy, pkt_done, w_data, wr_uart
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_priority_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx
);
  localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;
  logic             found;

  // Rotate so ptr lands at bit 0; the first set bit is then the offset from ptr.
  assign rot = N'({req, req} >> ptr);

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = IDX_W'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_W) sum = sum - N_W;
    idx    = sum[IDX_W-1:0];
    onehot = found ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing the UART tx FIFO write port among NUM_REQ sources.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8,
  parameter int LEN_BITS  = 4
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus,
  output arb_state_e         state_dbg
);
  localparam int IDX_W = idx_bits(NUM_REQ);

  arb_state_e           state;
  logic [NUM_REQ-1:0]   gnt;
  logic [IDX_W-1:0]     cur;
  logic [IDX_W-1:0]     ptr;
  logic [LEN_BITS-1:0]  remaining;
  logic                 pkt_done;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     next_ptr;
  logic                 cur_valid;
  logic [DATA_BITS-1:0] cur_data;
  logic                 hs;

  rr_priority_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign cur_valid = bus.req_valid[cur];
  assign cur_data  = bus.req_data[cur*DATA_BITS +: DATA_BITS];
  assign hs        = (state == XFER) && cur_valid && !bus.tx_full;
  assign next_ptr  = (cur == IDX_W'(NUM_REQ - 1)) ? '0 : cur + IDX_W'(1);

  always_comb begin
    bus.req_ready      = '0;
    bus.req_ready[cur] = hs;
  end

  assign bus.wr_uart  = hs;
  assign bus.w_data   = (state == XFER) ? cur_data : '0;
  assign bus.gnt      = gnt;
  assign bus.busy     = (state == XFER);
  assign bus.pkt_done = pkt_done;
  assign state_dbg    = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      cur       <= '0;
      ptr       <= '0;
      remaining <= '0;
      pkt_done  <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state     <= XFER;
            gnt       <= pick_onehot;
            cur       <= pick_idx;
            remaining <= bus.req_len[pick_idx*LEN_BITS +: LEN_BITS];
          end
        end
        XFER: begin
          // The grant is released only by the byte count, never by req dropping.
          if (hs) begin
            if (remaining != '0) begin
              remaining <= remaining - LEN_BITS'(1);
            end else begin
              state    <= IDLE;
              gnt      <= '0;
              pkt_done <= 1'b1;
              ptr      <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
